// File: rtl/cpu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_seq_pkg
//  Brief    : Opcodes, ALU codes, FSM states and the decoded control bundle
//             shared by the sequencing unit.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_seq_pkg;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;
  localparam logic [7:0] OP_LWD   = 8'd8;
  localparam logic [7:0] OP_LWI   = 8'd9;
  localparam logic [7:0] OP_SWD   = 8'd10;
  localparam logic [7:0] OP_SWI   = 8'd11;
  localparam logic [7:0] OP_MULT  = 8'd12;
  localparam logic [7:0] OP_BNE   = 8'd13;
  localparam logic [7:0] OP_SLL   = 8'd14;
  localparam logic [7:0] OP_SRL   = 8'd15;
  localparam logic [7:0] OP_ROR   = 8'd16;
  localparam logic [7:0] OP_SRA   = 8'd17;

  localparam logic [2:0] ALU_FWD   = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_MULT  = 3'd4;
  localparam logic [2:0] ALU_SHIFT = 3'd5;
  localparam logic [2:0] ALU_SRA   = 3'd6;
  localparam logic [2:0] ALU_ROR   = 3'd7;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] aluop;
    logic       sel_imm;
    logic       sel_neg;
    logic       shift_dir;
    logic       sel_dmem_alu;
    logic       we;
    logic       is_load;
    logic       is_store;
    logic       is_jump;
    logic       is_beq;
    logic       is_bne;
    logic       illegal;
  } ctrl_t;

  // Bundle for an instruction that does nothing; the ALU result path is the default writeback source.
  function automatic ctrl_t ctrl_nop();
    ctrl_t c;
    c              = '0;
    c.aluop        = ALU_FWD;
    c.sel_dmem_alu = 1'b1;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_seq_if
//  Brief    : Cache handshakes and datapath controls between the sequencer
//             (master) and the caches/ALU/register file (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface cpu_seq_if #(
  parameter int PC_W       = 32,
  parameter int REG_ADDR_W = 3
);
  logic                  IMEM_READ;
  logic [PC_W-1:0]       IMEM_ADDR;
  logic [31:0]           IMEM_RDATA;
  logic                  IMEM_BUSYWAIT;
  logic                  DMEM_READ;
  logic                  DMEM_WRITE;
  logic                  DMEM_BUSYWAIT;
  logic                  ZERO;
  logic [2:0]            ALUOP;
  logic                  SEL_IMM;
  logic                  SEL_NEG;
  logic                  SHIFT_DIR;
  logic                  SEL_DMEM_ALU;
  logic                  REG_WE;
  logic [REG_ADDR_W-1:0] RD_ADDR;
  logic [REG_ADDR_W-1:0] RT_ADDR;
  logic [REG_ADDR_W-1:0] RS_ADDR;
  logic [7:0]            IMM;
  logic [PC_W-1:0]       PC;
  logic                  ILLEGAL;

  modport master (
    output IMEM_READ, IMEM_ADDR, DMEM_READ, DMEM_WRITE,
    output ALUOP, SEL_IMM, SEL_NEG, SHIFT_DIR, SEL_DMEM_ALU,
    output REG_WE, RD_ADDR, RT_ADDR, RS_ADDR, IMM, PC, ILLEGAL,
    input  IMEM_RDATA, IMEM_BUSYWAIT, DMEM_BUSYWAIT, ZERO
  );

  modport slave (
    input  IMEM_READ, IMEM_ADDR, DMEM_READ, DMEM_WRITE,
    input  ALUOP, SEL_IMM, SEL_NEG, SHIFT_DIR, SEL_DMEM_ALU,
    input  REG_WE, RD_ADDR, RT_ADDR, RS_ADDR, IMM, PC, ILLEGAL,
    output IMEM_RDATA, IMEM_BUSYWAIT, DMEM_BUSYWAIT, ZERO
  );
endinterface
`default_nettype wire

// File: rtl/cpu_seq_decode.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_seq_decode
//  Brief    : Combinational opcode to control-bundle decoder. Opcodes 12-17
//             decode only when CPU_SEQ_EXT_OPS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_seq_decode
  import cpu_seq_pkg::*;
(
  input  logic [7:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = ctrl_nop();
    case (opcode)
      OP_LOADI: begin ctrl.sel_imm = 1'b1; ctrl.we = 1'b1; end
      OP_MOV:   begin ctrl.we = 1'b1; end
      OP_ADD:   begin ctrl.aluop = ALU_ADD; ctrl.we = 1'b1; end
      OP_SUB:   begin ctrl.aluop = ALU_ADD; ctrl.sel_neg = 1'b1; ctrl.we = 1'b1; end
      OP_AND:   begin ctrl.aluop = ALU_AND; ctrl.we = 1'b1; end
      OP_OR:    begin ctrl.aluop = ALU_OR;  ctrl.we = 1'b1; end
      OP_J:     begin ctrl.is_jump = 1'b1; end
      // Compare is a subtract; the ALU zero flag decides the branch.
      OP_BEQ:   begin ctrl.aluop = ALU_ADD; ctrl.sel_neg = 1'b1; ctrl.is_beq = 1'b1; end
      OP_LWD:   begin ctrl.is_load = 1'b1; ctrl.sel_dmem_alu = 1'b0; end
      OP_LWI:   begin ctrl.is_load = 1'b1; ctrl.sel_imm = 1'b1; ctrl.sel_dmem_alu = 1'b0; end
      OP_SWD:   begin ctrl.is_store = 1'b1; end
      OP_SWI:   begin ctrl.is_store = 1'b1; ctrl.sel_imm = 1'b1; end
`ifdef CPU_SEQ_EXT_OPS_EN
      OP_MULT:  begin ctrl.aluop = ALU_MULT; ctrl.we = 1'b1; end
      OP_BNE:   begin ctrl.aluop = ALU_ADD; ctrl.sel_neg = 1'b1; ctrl.is_bne = 1'b1; end
      OP_SLL:   begin ctrl.aluop = ALU_SHIFT; ctrl.sel_imm = 1'b1; ctrl.we = 1'b1; end
      OP_SRL:   begin ctrl.aluop = ALU_SHIFT; ctrl.sel_imm = 1'b1; ctrl.shift_dir = 1'b1; ctrl.we = 1'b1; end
      OP_ROR:   begin ctrl.aluop = ALU_ROR; ctrl.sel_imm = 1'b1; ctrl.we = 1'b1; end
      OP_SRA:   begin ctrl.aluop = ALU_SRA; ctrl.sel_imm = 1'b1; ctrl.we = 1'b1; end
`endif
      default:  begin ctrl.illegal = 1'b1; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_seq_ctrl
//  Brief    : FETCH/EXEC/MEM sequencer: holds PC, IR, the sticky illegal flag
//             and drives cache requests and datapath controls.
//             Optional macro: CPU_SEQ_EXT_OPS_EN (enables opcodes 12-17).
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int REG_ADDR_W = 3,
  parameter int OFFSET_W   = 8
) (
  input  logic      CLK,
  input  logic      RESET,
  cpu_seq_if.master bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic            first_q, first_d;
  logic            illegal_q, illegal_d;

  ctrl_t           ctrl;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] branch_off;
  logic [PC_W-1:0] next_pc;
  logic            taken;

  logic            imem_read;
  logic            dmem_read;
  logic            dmem_write;
  logic            reg_we;

  cpu_seq_decode u_decode (
    .opcode (ir_q[31:24]),
    .ctrl   (ctrl)
  );

  always_comb begin
    pc_plus4   = pc_q + PC_W'(4);
    branch_off = {{(PC_W-OFFSET_W){ir_q[16+OFFSET_W-1]}}, ir_q[16 +: OFFSET_W]} << 2;
    taken      = ctrl.is_jump | (ctrl.is_beq & bus.ZERO) | (ctrl.is_bne & ~bus.ZERO);
    next_pc    = taken ? (pc_plus4 + branch_off) : pc_plus4;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    first_d    = first_q;
    illegal_d  = illegal_q;
    imem_read  = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    reg_we     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_read = 1'b1;
        if (!bus.IMEM_BUSYWAIT) begin
          ir_d    = bus.IMEM_RDATA;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ctrl.is_load || ctrl.is_store) begin
          first_d = 1'b1;
          state_d = ST_MEM;
        end else begin
          reg_we    = ctrl.we;
          pc_d      = next_pc;
          illegal_d = illegal_q | ctrl.illegal;
          state_d   = ST_FETCH;
        end
      end
      ST_MEM: begin
        dmem_read  = ctrl.is_load;
        dmem_write = ctrl.is_store;
        first_d    = 1'b0;
        // The cache sees the request one cycle late, so its busywait is meaningless in the first MEM cycle.
        if (!first_q && !bus.DMEM_BUSYWAIT) begin
          reg_we  = ctrl.is_load;
          pc_d    = pc_plus4;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (RESET) begin
      imem_read  = 1'b0;
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
      reg_we     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      first_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      first_q   <= first_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.IMEM_READ    = imem_read;
  assign bus.IMEM_ADDR    = pc_q;
  assign bus.DMEM_READ    = dmem_read;
  assign bus.DMEM_WRITE   = dmem_write;
  assign bus.REG_WE       = reg_we;
  assign bus.ALUOP        = ctrl.aluop;
  assign bus.SEL_IMM      = ctrl.sel_imm;
  assign bus.SEL_NEG      = ctrl.sel_neg;
  assign bus.SHIFT_DIR    = ctrl.shift_dir;
  assign bus.SEL_DMEM_ALU = ctrl.sel_dmem_alu;
  assign bus.RD_ADDR      = ir_q[16 +: REG_ADDR_W];
  assign bus.RT_ADDR      = ir_q[8 +: REG_ADDR_W];
  assign bus.RS_ADDR      = ir_q[0 +: REG_ADDR_W];
  assign bus.IMM          = ir_q[7:0];
  assign bus.PC           = pc_q;
  assign bus.ILLEGAL      = illegal_q;

  // Register-field bits above REG_ADDR_W are reserved encoding space.
  logic unused_ir;
  assign unused_ir = ^ir_q;

endmodule
`default_nettype wire
